// File: rtl/des_pkg.sv
// Shared types, tables and rotate helpers for the DES key schedule.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef logic [27:0] half_key_t;
  typedef logic [55:0] cd_t;
  typedef logic [47:0] round_key_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ks_state_t;

  // Left-rotate amount per round, index 0 = round 1.
  localparam logic [1:0] SHIFT_TABLE [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // PC-2 selection, DES 1-based bit numbers of C||D; entry 0 drives subkey bit 1.
  localparam logic [5:0] PC2_TABLE [48] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  function automatic half_key_t rotl_half(input half_key_t h, input logic [1:0] amt);
    half_key_t r;
    case (amt)
      2'd1:    r = {h[26:0], h[27]};
      2'd2:    r = {h[25:0], h[27:26]};
      default: r = h;
    endcase
    return r;
  endfunction

  function automatic half_key_t rotr_half(input half_key_t h, input logic [1:0] amt);
    half_key_t r;
    case (amt)
      2'd1:    r = {h[0], h[27:1]};
      2'd2:    r = {h[1:0], h[27:2]};
      default: r = h;
    endcase
    return r;
  endfunction

  // C and D rotate independently; they never exchange bits.
  function automatic cd_t rotl_cd(input cd_t cd, input logic [1:0] amt);
    return {rotl_half(cd[55:28], amt), rotl_half(cd[27:0], amt)};
  endfunction

  function automatic cd_t rotr_cd(input cd_t cd, input logic [1:0] amt);
    return {rotr_half(cd[55:28], amt), rotr_half(cd[27:0], amt)};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: pure wiring from the 56-bit C||D to the 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  cd_t        cd,
  output round_key_t round_key
);

  // DES bit n of C||D lives at cd[56-n]; subkey bit 1 lives at round_key[47].
  for (genvar i = 0; i < 48; i++) begin : g_pc2
    localparam int SRC = 56 - int'(PC2_TABLE[i]);
    assign round_key[47 - i] = cd[SRC];
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: captures the PC-1 key on fPd and streams the 16 subkeys
// K1..K16 over a valid/ready interface, one subkey per accepted transfer.
// Optional build macro KS_DECRYPT_EN: when defined, decrypt (sampled with
// fPd) selects reverse order K16..K1; when undefined, decrypt is ignored.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = DES_ROUNDS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fPd,
  input  logic [55:0] droppedKey,
  input  logic       decrypt,
  output logic       rk_valid,
  input  logic       rk_ready,
  output round_key_t round_key,
  output logic [3:0] round_num,
  output logic       busy,
  output logic       fKs,
  output ks_state_t  dbg_state
);

  // Handshake: a subkey transfers on a rising edge where rk_valid && rk_ready.
  // While rk_valid is high and rk_ready is low, round_key and round_num are
  // held unchanged; rk_valid never drops without a transfer (except on rst).

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  ks_state_t  state, state_next;
  cd_t        cd, load_cd, step_cd;
  logic       accept, last_round;
  logic       load, advance, finish;
  logic [3:0] next_idx;

  assign accept     = rk_valid && rk_ready;
  assign last_round = (round_num == LAST_ROUND);
  assign next_idx   = round_num + 4'd1;
  assign dbg_state  = state;

`ifdef KS_DECRYPT_EN
  logic       dec_q;
  logic [3:0] rev_idx;

  // Direction is frozen for the whole schedule at the fPd that starts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= 1'b0;
    end else if (load) begin
      dec_q <= decrypt;
    end
  end

  // Reverse order starts from the unrotated key (total rotation is 28 = K16)
  // and undoes the encrypt shift of the round being left.
  assign rev_idx = 4'd15 - round_num;
  assign load_cd = decrypt ? droppedKey : rotl_cd(droppedKey, SHIFT_TABLE[0]);
  assign step_cd = dec_q ? rotr_cd(cd, SHIFT_TABLE[rev_idx])
                         : rotl_cd(cd, SHIFT_TABLE[next_idx]);
`else
  logic unused_decrypt;
  assign unused_decrypt = decrypt;
  assign load_cd = rotl_cd(droppedKey, SHIFT_TABLE[0]);
  assign step_cd = rotl_cd(cd, SHIFT_TABLE[next_idx]);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: fPd is only seen in IDLE, so it cannot restart a schedule.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fPd) state_next = RUN;
      RUN:     if (accept && last_round) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: datapath control strobes.
  always_comb begin
    load    = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: load = fPd;
      RUN: begin
        advance = accept && !last_round;
        finish  = accept && last_round;
      end
      default: ;
    endcase
  end

  // Datapath: C||D register, round counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cd        <= '0;
      round_num <= 4'd0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      fKs       <= 1'b0;
    end else begin
      fKs <= 1'b0;
      if (load) begin
        cd        <= load_cd;
        round_num <= 4'd0;
        rk_valid  <= 1'b1;
        busy      <= 1'b1;
      end else if (advance) begin
        cd        <= step_cd;
        round_num <= next_idx;
      end else if (finish) begin
        rk_valid <= 1'b0;
        busy     <= 1'b0;
        fKs      <= 1'b1;
      end
    end
  end

  des_pc2 u_pc2 (
    .cd        (cd),
    .round_key (round_key)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: reference subkeys of the classic DES example key,
// vector table plus hand sequences for latency, stall, ignored fPd and reset.
module tb_des_key_schedule;
  import des_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       fPd;
  logic [55:0] droppedKey;
  logic       decrypt;
  logic       rk_valid;
  logic       rk_ready;
  logic [47:0] round_key;
  logic [3:0] round_num;
  logic       busy;
  logic       fKs;
  ks_state_t  dbg_state;

  des_key_schedule dut (
    .clk        (clk),
    .rst        (rst),
    .fPd        (fPd),
    .droppedKey (droppedKey),
    .decrypt    (decrypt),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .round_key  (round_key),
    .round_num  (round_num),
    .busy       (busy),
    .fKs        (fKs),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  int fks_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference data ----------------
  typedef struct {
    logic [55:0]       key;
    logic              dec;
    logic [15:0][47:0] k;
    logic [15:0]       chk;
    int                stall;
  } vec_t;

  localparam logic [55:0] STD_KEY  = 56'hF0CCAAF556678F;
  localparam logic [55:0] WRAP_KEY = 56'h0000001_0000001;

  logic [15:0][47:0] std_k;
  logic [15:0][47:0] rev_k;
  vec_t vecs [4];

  // ---------------- scoreboard ----------------
  // entry = {check_enable, round_num, round_key}
  logic [52:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst && rk_valid && rk_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got subkey %h at round %0d, expected none", round_key, round_num);
      end else begin
        logic [52:0] e;
        e = exp_q.pop_front();
        check("sb_round_num", 64'(round_num), 64'(e[51:48]));
        if (e[52]) check("sb_round_key", 64'(round_key), 64'(e[47:0]));
      end
    end
    if (fKs === 1'b1) fks_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input vec_t v);
    for (int i = 0; i < 16; i++) exp_q.push_back({v.chk[i], 4'(i), v.k[i]});
  endtask

  // Pulses fPd for one cycle; returns #1 after the capturing edge.
  task automatic start(input vec_t v);
    fPd        = 1'b1;
    droppedKey = v.key;
    decrypt    = v.dec;
    push_vec(v);
    tick();
    fPd        = 1'b0;
    decrypt    = 1'b0;
    droppedKey = {24'($urandom), $urandom};
  endtask

  task automatic wait_round(input logic [3:0] n);
    int cnt = 0;
    while (!(rk_valid && round_num == n) && cnt < 40) begin
      tick();
      cnt++;
    end
    if (cnt >= 40) begin
      checks++;
      errors++;
      $display("FAIL wait_round: got timeout, expected round %0d", n);
    end
  endtask

  task automatic wait_done(input int stall);
    int cnt = 0;
    bit seen = 0;
    while (!seen && cnt < 300) begin
      rk_ready = (stall == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      tick();
      cnt++;
      if (fKs) seen = 1;
    end
    rk_ready = 1'b1;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done: got timeout, expected fKs pulse");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int fks0;

    rst = 1'b1; fPd = 1'b0; droppedKey = '0; decrypt = 1'b0; rk_ready = 1'b0;

    std_k[0]  = 48'h1B02EFFC7072; std_k[1]  = 48'h79AED9DBC9E5;
    std_k[2]  = 48'h55FC8A42CF99; std_k[3]  = 48'h72ADD6DB351D;
    std_k[4]  = 48'h7CEC07EB53A8; std_k[5]  = 48'h63A53E507B2F;
    std_k[6]  = 48'hEC84B7F618BC; std_k[7]  = 48'hF78A3AC13BFB;
    std_k[8]  = 48'hE0DBEBEDE781; std_k[9]  = 48'hB1F347BA464F;
    std_k[10] = 48'h215FD3DED386; std_k[11] = 48'h7571F59467E9;
    std_k[12] = 48'h97C5D1FABA41; std_k[13] = 48'h5F43B7F2E73A;
    std_k[14] = 48'hBF918D3D3F0A; std_k[15] = 48'hCB3D8B0E17F5;
    for (int i = 0; i < 16; i++) rev_k[i] = std_k[15 - i];

    vecs[0] = '{key: STD_KEY, dec: 1'b0, k: std_k, chk: 16'hFFFF, stall: 0};
    vecs[1] = '{key: STD_KEY, dec: 1'b0, k: std_k, chk: 16'hFFFF, stall: 1};
`ifdef KS_DECRYPT_EN
    vecs[2] = '{key: STD_KEY, dec: 1'b1, k: rev_k, chk: 16'hFFFF, stall: 0};
`else
    vecs[2] = '{key: STD_KEY, dec: 1'b1, k: std_k, chk: 16'hFFFF, stall: 0};
`endif
    vecs[3] = '{key: WRAP_KEY, dec: 1'b0, k: '0, chk: 16'h8001, stall: 1};
    vecs[3].k[0]  = 48'h000008040000;
    vecs[3].k[15] = 48'h010000000100;

    // reset values
    tick(); tick();
    check("rst_rk_valid", 64'(rk_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_fks", 64'(fKs), 64'd0);
    check("rst_round_num", 64'(round_num), 64'd0);
    check("rst_round_key", 64'(round_key), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rst = 1'b0;
    tick();

    // latency: K1 at t+1, K16 at t+16, fKs at t+17
    rk_ready = 1'b1;
    start(vecs[0]);
    check("lat_k1_valid", 64'(rk_valid), 64'd1);
    check("lat_k1_busy", 64'(busy), 64'd1);
    check("lat_k1_num", 64'(round_num), 64'd0);
    check("lat_k1_key", 64'(round_key), 64'(std_k[0]));
    for (int i = 1; i < 16; i++) begin
      tick();
      check("lat_key", 64'(round_key), 64'(std_k[i]));
    end
    check("lat_k16_num", 64'(round_num), 64'd15);
    tick();
    check("lat_fks_high", 64'(fKs), 64'd1);
    check("lat_done_valid", 64'(rk_valid), 64'd0);
    check("lat_done_busy", 64'(busy), 64'd0);
    tick();
    check("lat_fks_pulse", 64'(fKs), 64'd0);
    check("lat_hold_key", 64'(round_key), 64'(std_k[15]));
    check("lat_drain", 64'(exp_q.size()), 64'd0);

    // table-driven schedules
    for (int v = 0; v < 4; v++) begin
      start(vecs[v]);
      wait_done(vecs[v].stall);
      check("vec_hold_key", 64'(round_key), 64'(vecs[v].k[15]));
      check("vec_drain", 64'(exp_q.size()), 64'd0);
      tick();
    end

    // backpressure at round 4: hold for 3 cycles
    start(vecs[0]);
    wait_round(4'd4);
    rk_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 64'(rk_valid), 64'd1);
      check("stall_num", 64'(round_num), 64'd4);
      check("stall_key", 64'(round_key), 64'(std_k[4]));
    end
    wait_done(0);
    check("stall_drain", 64'(exp_q.size()), 64'd0);
    tick();

    // fPd with another key while busy is ignored
    fks0 = fks_seen;
    start(vecs[0]);
    wait_round(4'd7);
    fPd = 1'b1;
    droppedKey = 56'h123456789ABCDE;
    tick();
    fPd = 1'b0;
    check("busy_fpd_num", 64'(round_num), 64'd8);
    check("busy_fpd_key", 64'(round_key), 64'(std_k[8]));
    wait_done(0);
    tick();
    check("busy_fpd_drain", 64'(exp_q.size()), 64'd0);
    check("busy_fpd_fks", 64'(fks_seen - fks0), 64'd1);

    // reset mid-schedule at round 9
    start(vecs[0]);
    wait_round(4'd9);
    rk_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fks0 = fks_seen;
    check("midrst_valid", 64'(rk_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_key", 64'(round_key), 64'd0);
    check("midrst_num", 64'(round_num), 64'd0);
    exp_q.delete();
    rk_ready = 1'b1;
    repeat (20) tick();
    check("midrst_no_fks", 64'(fks_seen - fks0), 64'd0);
    check("midrst_idle", 64'(busy), 64'd0);
    start(vecs[0]);
    wait_done(0);
    check("midrst_restart_key", 64'(round_key), 64'(std_k[15]));
    tick();
    check("midrst_restart_drain", 64'(exp_q.size()), 64'd0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
